// File: rtl/lane_share_pkg.sv
// Shared types and helpers for the two-requester lane arbiter.
package lane_share_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    // Beat counter must hold 0..burst_max inclusive.
    function automatic int unsigned cnt_width(input int unsigned burst_max);
        return (burst_max < 1) ? 1 : $clog2(burst_max + 1);
    endfunction

endpackage

// File: rtl/lane_out_reg.sv
// Single valid/ready register stage: loads on accept, holds under backpressure,
// empties when drained with nothing new behind it.
module lane_out_reg #(
    parameter int unsigned W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] din_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] dout_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= din_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign dout_o  = data_q;

endmodule

// File: rtl/lane_share_arbiter.sv
// Round-robin arbiter with burst cap sharing one registered lane between two
// requesters; every lane beat carries the index of the requester it came from.
module lane_share_arbiter
    import lane_share_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             lane_valid,
    output logic [WIDTH-1:0] lane_data,
    output logic             lane_src,
    input  logic             lane_ready,
    output logic [1:0]       grant
);

    localparam int unsigned CW    = cnt_width(BURST_MAX);
    localparam int unsigned PAY_W = WIDTH + 1;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      grant_q, grant_d;

    logic             slot_free_c;
    logic             own_valid_c;
    logic             oth_valid_c;
    logic             accept_c;
    logic             release_c;
    logic [WIDTH-1:0] load_data_c;
    logic [PAY_W-1:0] lane_pay;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= SRC0;
            ptr_q   <= SRC0;
            cnt_q   <= '0;
            grant_q <= 2'b00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

    // Next-state: grant from IDLE, count beats, release on cap or owner going quiet
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        release_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    if (ptr_q == SRC1) begin
                        owner_d = req1_valid ? SRC1 : SRC0;
                    end else begin
                        owner_d = req0_valid ? SRC0 : SRC1;
                    end
                end
            end
            BUSY: begin
                if (accept_c) begin
                    cnt_d = cnt_q + CW'(1);
                end
                release_c = (accept_c && (cnt_q == CW'(BURST_MAX - 1)))
                          || (!own_valid_c && slot_free_c);
                if (release_c) begin
                    ptr_d = ~owner_q;
                    cnt_d = '0;
                    if (oth_valid_c) begin
                        owner_d = ~owner_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        grant_d = 2'b00;
        if (state_d == BUSY) begin
            grant_d = (owner_d == SRC1) ? 2'b10 : 2'b01;
        end
    end

    // Outputs: owner handshake and lane load; ready may follow lane_ready in-cycle
    always_comb begin
        slot_free_c = !lane_valid || lane_ready;
        own_valid_c = (owner_q == SRC1) ? req1_valid : req0_valid;
        oth_valid_c = (owner_q == SRC1) ? req0_valid : req1_valid;
        accept_c    = (state_q == BUSY) && slot_free_c && own_valid_c;
        req0_ready  = accept_c && (owner_q == SRC0);
        req1_ready  = accept_c && (owner_q == SRC1);
        load_data_c = (owner_q == SRC1) ? req1_data : req0_data;
    end

    lane_out_reg #(
        .W (PAY_W)
    ) u_lane_out_reg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (accept_c),
        .din_i   ({owner_q, load_data_c}),
        .ready_i (lane_ready),
        .valid_o (lane_valid),
        .dout_o  (lane_pay)
    );

    assign lane_src  = lane_pay[WIDTH];
    assign lane_data = lane_pay[WIDTH-1:0];
    assign grant     = grant_q;

endmodule

// File: tb/tb_lane_share_arbiter.sv
// Directed vector tables, hand sequences for reset/backpressure/hand-over, and a
// randomized scoreboard run for the two-requester lane arbiter.
module tb_lane_share_arbiter;

    localparam int unsigned BM = 4;
    localparam logic [31:0] DA = 32'h11223344;
    localparam logic [31:0] DB = 32'h44332211;
    localparam logic [31:0] DC = 32'h55667788;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0;
    logic [31:0] req0_data = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_data = '0;
    logic        req1_ready;
    logic        lane_valid;
    logic [31:0] lane_data;
    logic        lane_src;
    logic        lane_ready = 1'b0;
    logic [1:0]  grant;

    int total = 0;
    int bad   = 0;

    lane_share_arbiter #(.WIDTH(32), .BURST_MAX(BM)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .lane_valid (lane_valid),
        .lane_data  (lane_data),
        .lane_src   (lane_src),
        .lane_ready (lane_ready),
        .grant      (grant)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        logic        lr;
        logic        er0;
        logic        er1;
        logic        elv;
        logic [31:0] eld;
        logic        els;
        logic [1:0]  eg;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v0, input logic [31:0] d0, input logic v1,
                                input logic [31:0] d1, input logic lr, input logic er0,
                                input logic er1, input logic elv, input logic [31:0] eld,
                                input logic els, input logic [1:0] eg);
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.lr = lr;
        v.er0 = er0; v.er1 = er1; v.elv = elv; v.eld = eld; v.els = els; v.eg = eg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; lane_ready = 1'b0;
        req0_data = '0; req1_data = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input logic v0, input logic [31:0] d0, input logic v1,
                        input logic [31:0] d1, input logic lr);
        @(negedge clk);
        req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1; lane_ready = lr;
        #1;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].lr);
            chk({tag, "_rdy0"}, 32'(req0_ready), 32'(tbl[i].er0));
            chk({tag, "_rdy1"}, 32'(req1_ready), 32'(tbl[i].er1));
            chk({tag, "_lvalid"}, 32'(lane_valid), 32'(tbl[i].elv));
            chk({tag, "_grant"}, 32'(grant), 32'(tbl[i].eg));
            if (tbl[i].elv) begin
                chk({tag, "_ldata"}, lane_data, tbl[i].eld);
                chk({tag, "_lsrc"}, 32'(lane_src), 32'(tbl[i].els));
            end
        end
        tbl.delete();
    endtask

    // Random phase state
    logic        p0 = 1'b0, p1 = 1'b0;
    logic [31:0] d0r = '0, d1r = '0;
    int unsigned seq0 = 0, seq1 = 0;
    logic [31:0] q0[$], q1[$];
    logic        hold_pend = 1'b0;
    logic [31:0] hold_d = '0;
    logic        hold_s = 1'b0;
    logic [1:0]  prev_g = 2'b00;
    int          burst = 0;
    int          w0 = 0, w1 = 0;

    task automatic rand_cycle(input bit gen, input bit rand_lr);
        @(negedge clk);
        if (gen && !p0 && ($urandom_range(0, 3) != 0)) begin
            p0 = 1'b1; d0r = {8'hA0, 24'(seq0)}; seq0++;
        end
        if (gen && !p1 && ($urandom_range(0, 3) != 0)) begin
            p1 = 1'b1; d1r = {8'hB1, 24'(seq1)}; seq1++;
        end
        req0_valid = p0; req0_data = d0r;
        req1_valid = p1; req1_data = d1r;
        lane_ready = rand_lr ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        if (hold_pend) begin
            chk("rnd_hold_valid", 32'(lane_valid), 32'd1);
            chk("rnd_hold_data", lane_data, hold_d);
            chk("rnd_hold_src", 32'(lane_src), 32'(hold_s));
        end
        hold_pend = lane_valid && !lane_ready;
        hold_d = lane_data;
        hold_s = lane_src;
        if (lane_valid && lane_ready) begin
            if (lane_src) begin
                if (q1.size() == 0) chk("rnd_sb1_dup", lane_data, 32'hFFFFFFFF);
                else chk("rnd_sb1", lane_data, q1.pop_front());
            end else begin
                if (q0.size() == 0) chk("rnd_sb0_dup", lane_data, 32'hFFFFFFFF);
                else chk("rnd_sb0", lane_data, q0.pop_front());
            end
        end
        chk("rnd_grant_legal", 32'(grant == 2'b00 || grant == 2'b01 || grant == 2'b10), 32'd1);
        chk("rnd_rdy0_gnt", 32'(req0_ready && (grant != 2'b01 || !req0_valid)), 32'd0);
        chk("rnd_rdy1_gnt", 32'(req1_ready && (grant != 2'b10 || !req1_valid)), 32'd0);
        if (grant != prev_g) burst = 0;
        prev_g = grant;
        if (req0_ready || req1_ready) begin
            burst++;
            chk("rnd_burst_cap", 32'(burst), (burst <= int'(BM)) ? 32'(burst) : 32'(BM));
        end
        if (req0_ready) w0 = 0;
        else if (req0_valid && lane_ready) w0++;
        if (req1_ready) w1 = 0;
        else if (req1_valid && lane_ready) w1++;
        if (w0 > int'(2 * BM + 2)) chk("rnd_starve0", 32'(w0), 32'(2 * BM + 2));
        if (w1 > int'(2 * BM + 2)) chk("rnd_starve1", 32'(w1), 32'(2 * BM + 2));
        if (req0_valid && req0_ready) begin q0.push_back(d0r); p0 = 1'b0; end
        if (req1_valid && req1_ready) begin q1.push_back(d1r); p1 = 1'b0; end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_lvalid", 32'(lane_valid), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ldata", lane_data, 32'd0);
        chk("rst_lsrc", 32'(lane_src), 32'd0);
        do_reset();

        // Solo req0, burst cap then one idle-grant cycle
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 2'b01));
        tbl.push_back(mk(1, 2, 0, 0, 1, 1, 0, 1, 1, 0, 2'b01));
        tbl.push_back(mk(1, 3, 0, 0, 1, 1, 0, 1, 2, 0, 2'b01));
        tbl.push_back(mk(1, 4, 0, 0, 1, 1, 0, 1, 3, 0, 2'b01));
        tbl.push_back(mk(1, 5, 0, 0, 1, 0, 0, 1, 4, 0, 2'b00));
        tbl.push_back(mk(1, 5, 0, 0, 1, 1, 0, 0, 0, 0, 2'b01));
        tbl.push_back(mk(1, 6, 0, 0, 1, 1, 0, 1, 5, 0, 2'b01));
        tbl.push_back(mk(0, 6, 0, 0, 1, 0, 0, 1, 6, 0, 2'b01));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00));
        run_table("solo");

        // Both requesting: four src0 beats then four src1 beats without a bubble
        do_reset();
        tbl.push_back(mk(1, DA, 1, DB, 1, 0, 0, 0, 0, 0, 2'b00));
        tbl.push_back(mk(1, DA, 1, DB, 1, 1, 0, 0, 0, 0, 2'b01));
        tbl.push_back(mk(1, DA, 1, DB, 1, 1, 0, 1, DA, 0, 2'b01));
        tbl.push_back(mk(1, DA, 1, DB, 1, 1, 0, 1, DA, 0, 2'b01));
        tbl.push_back(mk(1, DA, 1, DB, 1, 1, 0, 1, DA, 0, 2'b01));
        tbl.push_back(mk(1, DA, 1, DB, 1, 0, 1, 1, DA, 0, 2'b10));
        tbl.push_back(mk(1, DA, 1, DB, 1, 0, 1, 1, DB, 1, 2'b10));
        tbl.push_back(mk(1, DA, 1, DB, 1, 0, 1, 1, DB, 1, 2'b10));
        tbl.push_back(mk(1, DA, 1, DB, 1, 0, 1, 1, DB, 1, 2'b10));
        tbl.push_back(mk(1, DA, 1, DB, 1, 1, 0, 1, DB, 1, 2'b01));
        run_table("both");

        // Backpressure holds the loaded beat; release accepts next beat same cycle
        do_reset();
        step(0, 0, 1, DB, 1);
        chk("bp_idle_grant", 32'(grant), 32'd0);
        step(0, 0, 1, DB, 1);
        chk("bp_first_rdy1", 32'(req1_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, DC, 0);
            chk("bp_hold_valid", 32'(lane_valid), 32'd1);
            chk("bp_hold_data", lane_data, DB);
            chk("bp_hold_src", 32'(lane_src), 32'd1);
            chk("bp_hold_rdy1", 32'(req1_ready), 32'd0);
        end
        step(0, 0, 1, DC, 1);
        chk("bp_release_rdy1", 32'(req1_ready), 32'd1);
        chk("bp_release_data", lane_data, DB);
        step(0, 0, 0, 0, 1);
        chk("bp_next_data", lane_data, DC);
        chk("bp_next_valid", 32'(lane_valid), 32'd1);

        // Owner drops valid after two beats; req1 takes over, req0 served after
        do_reset();
        step(1, 32'hA, 1, DB, 1);
        chk("ho_idle_grant", 32'(grant), 32'd0);
        step(1, 32'hA, 1, DB, 1);
        chk("ho_beat1_rdy0", 32'(req0_ready), 32'd1);
        step(1, 32'hB, 1, DB, 1);
        chk("ho_beat2_rdy0", 32'(req0_ready), 32'd1);
        step(0, 32'hB, 1, DB, 1);
        chk("ho_drop_grant", 32'(grant), 32'h1);
        chk("ho_drop_rdy1", 32'(req1_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1, 32'hC, 1, DB, 1);
            chk("ho_r1_grant", 32'(grant), 32'h2);
            chk("ho_r1_rdy1", 32'(req1_ready), 32'd1);
            chk("ho_r1_rdy0", 32'(req0_ready), 32'd0);
        end
        step(1, 32'hC, 1, DB, 1);
        chk("ho_back_grant", 32'(grant), 32'h1);
        chk("ho_back_rdy0", 32'(req0_ready), 32'd1);

        // Asynchronous reset in the middle of a burst
        do_reset();
        step(1, DA, 0, 0, 1);
        step(1, DA, 0, 0, 1);
        chk("mr_rdy0", 32'(req0_ready), 32'd1);
        step(1, DA, 0, 0, 1);
        chk("mr_lvalid_pre", 32'(lane_valid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("mr_lvalid", 32'(lane_valid), 32'd0);
        chk("mr_grant", 32'(grant), 32'd0);
        chk("mr_rdy0_in_reset", 32'(req0_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mr_after_idle", 32'(grant), 32'd0);
        step(1, DA, 0, 0, 1);
        chk("mr_regrant", 32'(grant), 32'h1);
        chk("mr_regrant_rdy0", 32'(req0_ready), 32'd1);

        // Random valid/ready traffic checked by per-source scoreboard
        do_reset();
        for (int i = 0; i < 10000; i++) rand_cycle(1'b1, 1'b1);
        for (int i = 0; i < 40; i++) rand_cycle(1'b0, 1'b0);
        chk("rnd_q0_empty", 32'(q0.size()), 32'd0);
        chk("rnd_q1_empty", 32'(q1.size()), 32'd0);
        chk("rnd_p0_done", 32'(p0), 32'd0);
        chk("rnd_p1_done", 32'(p1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
